// File: rtl/di_term_router_if.sv
// ============================================================================
// Module      : di_term_router_if
// Description : Host-side bus of the terminal router: address, transfer
//               qualifiers, strobes, read data and ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface di_term_router_if;
  logic [15:0] di_term_addr;
  logic        di_read_mode;
  logic        di_write_mode;
  logic        di_read_req;
  logic        di_read;
  logic        di_write;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy;
  logic        di_write_rdy;

  // Host side: issues addresses and strobes, receives data and ready.
  modport master (
    output di_term_addr, di_read_mode, di_write_mode,
           di_read_req, di_read, di_write,
    input  di_reg_datao, di_read_rdy, di_write_rdy
  );

  // Router side: the mirror image of the host.
  modport slave (
    input  di_term_addr, di_read_mode, di_write_mode,
           di_read_req, di_read, di_write,
    output di_reg_datao, di_read_rdy, di_write_rdy
  );
endinterface

`default_nettype wire

// File: rtl/di_term_router.sv
// ============================================================================
// Module      : di_term_router
// Description : Routes host-interface transfers to one of NTERM terminals by
//               address. A terminal that holds ready low for too long is cut
//               off: the host sees ready with fill data until it drops its
//               transfer mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module di_term_router #(
  parameter int                    NTERM     = 4,
  parameter logic [16*NTERM-1:0]   TERM_ADDR = {16'h0003, 16'h0002, 16'h0001, 16'h0000},
  parameter int                    TIMEOUT   = 1024,
  parameter logic [15:0]           FILL_DATA = 16'hDEAD,
  parameter logic [15:0]           DEF_DATA  = 16'hAAAA
) (
  input  wire logic                 ifclk,
  input  wire logic                 reset,
  di_term_router_if.slave           host,
  input  wire logic [16*NTERM-1:0]  t_datao,
  input  wire logic [NTERM-1:0]     t_read_rdy,
  input  wire logic [NTERM-1:0]     t_write_rdy,
  output logic      [NTERM-1:0]     t_sel,
  output logic      [NTERM-1:0]     t_read_req,
  output logic      [NTERM-1:0]     t_read,
  output logic      [NTERM-1:0]     t_write,
  output logic                      timeout,
  output logic      [7:0]           timeout_count
);

  // Wait counter is wide enough to hold TIMEOUT-1 with headroom.
  localparam int               c_CW   = $clog2(TIMEOUT) + 1;
  localparam logic [c_CW-1:0]  c_LAST = c_CW'(TIMEOUT - 1);
  localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_TIMEDOUT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       addr_q;
  logic              timeout_q, timeout_d;
  logic [7:0]        count_q, count_d;

  logic [NTERM-1:0]  w_sel;
  logic [15:0]       w_sel_data;
  logic              w_sel_rrdy;
  logic              w_sel_wrdy;
  logic              w_to;
  logic              w_modes;
  logic              w_stall;
  logic              w_addr_chg;
  logic [c_CW-1:0]   w_cnt_inc;

  // Address decode; scanning downward lets the lowest matching slot win.
  // Unmapped addresses leave the defaults: no select, ready high, DEF_DATA.
  always_comb begin
    w_sel      = '0;
    w_sel_data = DEF_DATA;
    w_sel_rrdy = 1'b1;
    w_sel_wrdy = 1'b1;
    for (int i = NTERM - 1; i >= 0; i--) begin
      if (host.di_term_addr == TERM_ADDR[16*i +: 16]) begin
        w_sel      = '0;
        w_sel[i]   = 1'b1;
        w_sel_data = t_datao[16*i +: 16];
        w_sel_rrdy = t_read_rdy[i];
        w_sel_wrdy = t_write_rdy[i];
      end
    end
  end

  assign w_to    = (state_q == S_TIMEDOUT);
  assign w_modes = host.di_read_mode | host.di_write_mode;

  assign t_sel             = w_sel;
  assign host.di_read_rdy  = w_to | w_sel_rrdy;
  assign host.di_write_rdy = w_to | w_sel_wrdy;
  assign t_read_req        = w_to ? '0 : ({NTERM{host.di_read_req}} & w_sel);
  assign t_read            = w_to ? '0 : ({NTERM{host.di_read}}     & w_sel);
  assign t_write           = w_to ? '0 : ({NTERM{host.di_write}}    & w_sel);

  assign w_stall    = (host.di_read_mode  & ~host.di_read_rdy) |
                      (host.di_write_mode & ~host.di_write_rdy);
  assign w_addr_chg = (host.di_term_addr != addr_q);
  assign w_cnt_inc  = cnt_q + c_ONE;

  // Next state, wait counter and timeout pulse; a mode drop beats expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_modes) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!w_modes) begin
          state_d = S_IDLE;
        end else if (w_stall && !w_addr_chg) begin
          if (w_cnt_inc == c_LAST) begin
            state_d   = S_TIMEDOUT;
            timeout_d = 1'b1;
          end else begin
            cnt_d = w_cnt_inc;
          end
        end
      end
      S_TIMEDOUT: begin
        if (!w_modes) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data is captured every cycle; TIMEDOUT overrides with fill data.
  always_comb begin
    data_d  = w_to ? FILL_DATA : w_sel_data;
    count_d = (timeout_q && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
  end

  // State and datapath registers.
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= 16'h0000;
      addr_q    <= 16'h0000;
      timeout_q <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      addr_q    <= host.di_term_addr;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign host.di_reg_datao = data_q;
  assign timeout           = timeout_q;
  assign timeout_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_di_term_router.sv
// ============================================================================
// Module      : tb_di_term_router
// Description : Directed bench for di_term_router with a behavioural model
//               checked every cycle plus literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_di_term_router;
  localparam int          NT = 4;
  localparam int          TO = 16;
  // Slot 3 duplicates slot 1, so address 1 must always pick slot 1.
  localparam logic [63:0] TA = {16'h0001, 16'h0020, 16'h0001, 16'h0000};

  logic        ifclk = 1'b0;
  logic        reset;
  logic [63:0] t_datao;
  logic [3:0]  t_read_rdy, t_write_rdy;
  wire  [3:0]  t_sel, t_read_req, t_read, t_write;
  wire         timeout;
  wire  [7:0]  timeout_count;

  di_term_router_if hif ();

  di_term_router #(
    .NTERM(NT), .TERM_ADDR(TA), .TIMEOUT(TO),
    .FILL_DATA(16'hDEAD), .DEF_DATA(16'hAAAA)
  ) u_dut (
    .ifclk(ifclk), .reset(reset), .host(hif),
    .t_datao(t_datao), .t_read_rdy(t_read_rdy), .t_write_rdy(t_write_rdy),
    .t_sel(t_sel), .t_read_req(t_read_req), .t_read(t_read), .t_write(t_write),
    .timeout(timeout), .timeout_count(timeout_count)
  );

  always #5 ifclk = ~ifclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int find_slot(input logic [15:0] a);
    logic [63:0] slots;
    slots = TA;
    for (int i = 0; i < NT; i++)
      if (slots[16*i +: 16] == a) return i;
    return -1;
  endfunction

  // ---------------------------------------------------------------- model
  // The model tracks "transfer open", "terminal cut off", the length of the
  // current uninterrupted stall run at one address, and the registered
  // outputs the DUT must present after the coming edge.
  bit          m_open, m_cut, m_pulse;
  int          m_run, m_count;
  logic [15:0] m_prev, m_data;

  always @(negedge ifclk) begin
    int          idx;
    logic [3:0]  e_sel, e_rq, e_rd, e_wr;
    logic        e_rr, e_wrdy, modes, stall;
    logic [15:0] nxt;

    if (reset) begin
      m_open = 0; m_cut = 0; m_pulse = 0; m_run = 0; m_count = 0;
      m_prev = 16'h0000; m_data = 16'h0000;
    end

    idx   = find_slot(hif.di_term_addr);
    e_sel = (idx >= 0) ? 4'(1 << idx) : 4'b0000;
    if (m_cut) begin
      e_rr = 1'b1; e_wrdy = 1'b1; e_rq = '0; e_rd = '0; e_wr = '0;
    end else begin
      e_rr   = (idx >= 0) ? t_read_rdy[idx]  : 1'b1;
      e_wrdy = (idx >= 0) ? t_write_rdy[idx] : 1'b1;
      e_rq   = hif.di_read_req ? e_sel : 4'b0000;
      e_rd   = hif.di_read     ? e_sel : 4'b0000;
      e_wr   = hif.di_write    ? e_sel : 4'b0000;
    end

    chk("t_sel",         64'(t_sel),            64'(e_sel));
    chk("di_read_rdy",   64'(hif.di_read_rdy),  64'(e_rr));
    chk("di_write_rdy",  64'(hif.di_write_rdy), 64'(e_wrdy));
    chk("t_read_req",    64'(t_read_req),       64'(e_rq));
    chk("t_read",        64'(t_read),           64'(e_rd));
    chk("t_write",       64'(t_write),          64'(e_wr));
    chk("di_reg_datao",  64'(hif.di_reg_datao), 64'(m_data));
    chk("timeout",       64'(timeout),          64'(m_pulse));
    chk("timeout_count", 64'(timeout_count),    64'(m_count));

    if (!reset) begin
      modes = hif.di_read_mode | hif.di_write_mode;
      stall = (hif.di_read_mode & ~e_rr) | (hif.di_write_mode & ~e_wrdy);
      nxt   = m_cut ? 16'hDEAD : ((idx >= 0) ? t_datao[16*idx +: 16] : 16'hAAAA);
      if (m_pulse && m_count < 255) m_count++;
      m_pulse = 0;
      if (m_cut) begin
        if (!modes) m_cut = 0;
      end else if (m_open) begin
        if (!modes) begin
          m_open = 0; m_run = 0;
        end else begin
          m_run = (stall && hif.di_term_addr == m_prev) ? m_run + 1 : 0;
          // TIMEOUT-1 counted stall cycles cut the terminal off.
          if (m_run == TO - 1) begin
            m_open = 0; m_cut = 1; m_pulse = 1; m_run = 0;
          end
        end
      end else if (modes) begin
        m_open = 1; m_run = 0;
      end
      m_prev = hif.di_term_addr;
      m_data = nxt;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge ifclk);
    #1;
  endtask

  task automatic modes_off();
    hif.di_read_mode = 0; hif.di_write_mode = 0;
    hif.di_read = 0; hif.di_write = 0; hif.di_read_req = 0;
  endtask

  // Counts edges until timeout pulses, bounded to TO+6.
  task automatic wait_to(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!timeout && n < TO + 6);
  endtask

  initial begin
    int n;
    bit seen;

    reset = 1;
    hif.di_term_addr = 16'h0000;
    modes_off();
    t_datao     = {16'h4444, 16'h3333, 16'h1234, 16'h1111};
    t_read_rdy  = 4'b1111;
    t_write_rdy = 4'b1111;

    tick(1);
    chk("rst_data",  64'(hif.di_reg_datao), 64'h0);
    chk("rst_to",    64'(timeout),          64'h0);
    chk("rst_count", 64'(timeout_count),    64'h0);
    hif.di_term_addr = 16'h0001; hif.di_read = 1;
    #1;
    chk("rst_comb_t_read", 64'(t_read), 64'b0010);
    tick(2);
    hif.di_read = 0;
    reset = 0;
    tick(2);

    // Basic read on slot 1 (also shadowed by duplicate slot 3).
    hif.di_read_mode = 1; hif.di_read = 1; hif.di_read_req = 1;
    #1;
    chk("sel_slot1",   64'(t_sel),      64'b0010);
    chk("read_slot1",  64'(t_read),     64'b0010);
    chk("rreq_slot1",  64'(t_read_req), 64'b0010);
    tick(1);
    chk("data_slot1",  64'(hif.di_reg_datao), 64'h1234);
    t_datao[31:16] = 16'h5678;
    #1;
    chk("data_latency", 64'(hif.di_reg_datao), 64'h1234);
    tick(1);
    chk("data_update",  64'(hif.di_reg_datao), 64'h5678);
    modes_off();
    tick(2);

    // Write on slot 2 with its write-ready low.
    hif.di_term_addr = 16'h0020; hif.di_write_mode = 1; hif.di_write = 1;
    t_write_rdy = 4'b1011;
    #1;
    chk("write_slot2",  64'(t_write),          64'b0100);
    chk("wrdy_slot2",   64'(hif.di_write_rdy), 64'h0);
    t_write_rdy = 4'b1111;
    modes_off();
    tick(2);

    // Unmapped address.
    hif.di_term_addr = 16'h00FF; hif.di_read_mode = 1; hif.di_read = 1;
    #1;
    chk("unmap_sel",  64'(t_sel),           64'h0);
    chk("unmap_rdy",  64'(hif.di_read_rdy), 64'h1);
    tick(1);
    chk("unmap_data", 64'(hif.di_reg_datao), 64'hAAAA);
    modes_off();
    tick(2);

    // Timeout on slot 1.
    hif.di_term_addr = 16'h0001; t_read_rdy = 4'b1101;
    hif.di_read_mode = 1; hif.di_read = 1;
    wait_to(n);
    chk("to_latency", 64'(n), 64'(TO));
    chk("to_rdy",     64'(hif.di_read_rdy), 64'h1);
    chk("to_t_read",  64'(t_read),          64'h0);
    tick(1);
    chk("to_fill",    64'(hif.di_reg_datao), 64'hDEAD);
    chk("to_count",   64'(timeout_count),    64'h1);
    chk("to_single",  64'(timeout),          64'h0);
    modes_off();
    tick(2);

    // Stall TO-2 cycles, ready for one, then stall again.
    hif.di_read_mode = 1; hif.di_read = 1;
    seen = 0;
    for (int i = 0; i < TO - 2; i++) begin tick(1); seen |= timeout; end
    t_read_rdy = 4'b1111;
    tick(1); seen |= timeout;
    chk("gap_no_to", 64'(seen), 64'h0);
    t_read_rdy = 4'b1101;
    wait_to(n);
    chk("gap_fresh", 64'(n), 64'(TO - 1));
    modes_off();
    tick(2);

    // Address change while ACTIVE restarts the wait; in TIMEDOUT it does not exit.
    t_read_rdy = 4'b1001;
    hif.di_read_mode = 1; hif.di_read = 1;
    tick(TO - 3);
    hif.di_term_addr = 16'h0020;
    #1;
    chk("reroute_sel", 64'(t_sel), 64'b0100);
    wait_to(n);
    chk("reroute_to", 64'(n), 64'(TO));
    hif.di_term_addr = 16'h0001;
    tick(1);
    chk("to_hold_rdy", 64'(hif.di_read_rdy), 64'h1);
    chk("to_hold_rd",  64'(t_read),          64'h0);
    modes_off();
    t_read_rdy = 4'b1101;
    tick(2);

    // Mode dropped on the would-be expiry cycle.
    hif.di_read_mode = 1; hif.di_read = 1;
    tick(TO - 1);
    modes_off();
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(1); seen |= timeout; end
    chk("drop_no_to", 64'(seen), 64'h0);
    chk("drop_count", 64'(timeout_count), 64'h3);

    // Saturation.
    for (int k = 0; k < 300; k++) begin
      hif.di_read_mode = 1; hif.di_read = 1;
      wait_to(n);
      modes_off();
      tick(1);
    end
    tick(2);
    chk("count_sat", 64'(timeout_count), 64'hFF);

    // Reset during TIMEDOUT.
    hif.di_read_mode = 1; hif.di_read = 1;
    wait_to(n);
    tick(1);
    reset = 1;
    #1;
    chk("rst_to_rdy",   64'(hif.di_read_rdy),  64'h0);
    chk("rst_to_count", 64'(timeout_count),    64'h0);
    chk("rst_to_data",  64'(hif.di_reg_datao), 64'h0);
    tick(1);
    reset = 0;
    modes_off();
    t_read_rdy = 4'b1111;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
